// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command stream to single APB transfers, one outstanding
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_psel_nxt;
  logic              w_penable_nxt;
  logic              w_pwrite_nxt;
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic [DATA_W-1:0] w_pwdata_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_rsp_err_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;

  logic w_cmd_ready;
  logic w_accept;
  logic w_done;
  logic w_abort;

  // A pending response blocks new commands, so a completion never overwrites an unread one.
  assign w_cmd_ready = (r_state == ST_IDLE) && (!r_rsp_valid || rsp_ready);
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_done      = (r_state == ST_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_tmo_cnt;

  // Abort on the edge ending the TIMEOUT_CYCLES-th stalled ACCESS cycle; PREADY=1 wins.
  assign w_abort = (r_state == ST_ACCESS) && !PREADY &&
                   (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !PREADY) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (w_done || w_abort) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered APB and response outputs.
  always_comb begin
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;

    if (r_rsp_valid && rsp_ready) begin
      w_rsp_valid_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = cmd_write;
          w_paddr_nxt   = cmd_addr;
          w_pwdata_nxt  = cmd_wdata;
        end
      end
      ST_SETUP: begin
        w_penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (w_done) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
        end else if (w_abort) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
        end
      end
      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != ST_IDLE);
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed bench for apb_master_bridge
// Table of single transfers plus hand sequences for reset, response backpressure and timeout.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        PSEL;
  logic        PENABLE;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_vec  = -1;

  apb_master_bridge #(
    .ADDR_W(8),
    .DATA_W(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy),
    .PSEL(PSEL),
    .PENABLE(PENABLE),
    .PADDR(PADDR),
    .PWRITE(PWRITE),
    .PWDATA(PWDATA),
    .PREADY(PREADY),
    .PRDATA(PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          wait_cyc;
    int          rsp_delay;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", cur_vec, name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    PRDATA    = v.prdata;
    PREADY    = (v.wait_cyc == 0);
    rsp_ready = 1'b0;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = ~v.write;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", PWRITE, v.write);
    chk("setup_pwdata", PWDATA, v.wdata);
    chk("setup_busy", busy, 1);
    chk("setup_cmd_ready", cmd_ready, 0);
    @(negedge PCLK);
    chk("access_psel", PSEL, 1);
    chk("access_penable", PENABLE, 1);
    chk("access_rsp_valid", rsp_valid, 0);
    for (int k = 0; k < v.wait_cyc; k++) begin
      @(negedge PCLK);
      chk("wait_psel", PSEL, 1);
      chk("wait_penable", PENABLE, 1);
      chk("wait_paddr", PADDR, v.addr);
      chk("wait_pwrite", PWRITE, v.write);
      chk("wait_pwdata", PWDATA, v.wdata);
      chk("wait_rsp_valid", rsp_valid, 0);
    end
    PREADY = 1'b1;
    @(negedge PCLK);
    PREADY = 1'b0;
    chk("done_rsp_valid", rsp_valid, 1);
    chk("done_rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("done_rsp_err", rsp_err, 0);
    chk("done_psel", PSEL, 0);
    chk("done_penable", PENABLE, 0);
    chk("done_busy", busy, 0);
    for (int j = 0; j < v.rsp_delay; j++) begin
      chk("hold_cmd_ready", cmd_ready, 0);
      @(negedge PCLK);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
    end
    rsp_ready = 1'b1;
    #1 chk("pop_cmd_ready", cmd_ready, 1);
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("pop_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    // write, addr, wdata, prdata, wait_cyc, rsp_delay, exp_rdata
    vecs[0] = '{1'b1, 8'h10, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 0, 32'h0000_0000};
    vecs[1] = '{1'b0, 8'h10, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 8'h3F, 32'h1234_5678, 32'h5555_AAAA, 3, 0, 32'h0000_0000};
    vecs[3] = '{1'b0, 8'h3F, 32'hFFFF_0000, 32'h1234_5678, 1, 2, 32'h1234_5678};
    vecs[4] = '{1'b0, 8'hFF, 32'h0000_0000, 32'hA5A5_A5A5, 0, 1, 32'hA5A5_A5A5};
    vecs[5] = '{1'b1, 8'h00, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 2, 0, 32'h0000_0000};
    vecs[6] = '{1'b0, 8'h80, 32'h0000_0000, 32'h8000_0001, 0, 0, 32'h8000_0001};

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = 32'h0;

    repeat (2) @(negedge PCLK);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    PRESETn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // Response held under backpressure while a changing command waits.
    cur_vec = 100;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h20;
    cmd_wdata = 32'h1111_2222;
    PREADY    = 1'b1;
    PRDATA    = 32'h9999_9999;
    rsp_ready = 1'b0;
    @(negedge PCLK);
    cmd_write = 1'b0;
    cmd_addr  = 8'h21;
    chk("bp_setup_paddr", PADDR, 8'h20);
    @(negedge PCLK);
    chk("bp_access_paddr", PADDR, 8'h20);
    @(negedge PCLK);
    chk("bp_done_rsp_valid", rsp_valid, 1);
    chk("bp_done_rdata", rsp_rdata, 0);
    for (int j = 0; j < 5; j++) begin
      cmd_addr = 8'h22 + 8'(j);
      chk("bp_cmd_ready", cmd_ready, 0);
      @(negedge PCLK);
      chk("bp_hold_rsp_valid", rsp_valid, 1);
      chk("bp_hold_rsp_rdata", rsp_rdata, 0);
      chk("bp_hold_rsp_err", rsp_err, 0);
      chk("bp_hold_psel", PSEL, 0);
      chk("bp_hold_busy", busy, 0);
    end
    cmd_addr  = 8'h30;
    cmd_write = 1'b0;
    PRDATA    = 32'h1357_2468;
    rsp_ready = 1'b1;
    #1 chk("bp_release_cmd_ready", cmd_ready, 1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("bp_next_rsp_valid", rsp_valid, 0);
    chk("bp_next_psel", PSEL, 1);
    chk("bp_next_paddr", PADDR, 8'h30);
    chk("bp_next_pwrite", PWRITE, 0);
    @(negedge PCLK);
    chk("bp_next_penable", PENABLE, 1);
    @(negedge PCLK);
    PREADY = 1'b0;
    chk("bp_next_rsp_valid2", rsp_valid, 1);
    chk("bp_next_rdata", rsp_rdata, 32'h1357_2468);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("bp_next_pop", rsp_valid, 0);

    // Asynchronous reset in the middle of ACCESS drops the transfer.
    cur_vec = 101;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h44;
    cmd_wdata = 32'h4444_4444;
    PREADY    = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    chk("rst_mid_psel_before", PSEL, 1);
    chk("rst_mid_penable_before", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", PSEL, 0);
    chk("rst_mid_penable", PENABLE, 0);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_paddr", PADDR, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge PCLK);
      chk("rst_after_rsp_valid", rsp_valid, 0);
      chk("rst_after_psel", PSEL, 0);
    end
    PREADY = 1'b0;

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave: abort after 16 stalled ACCESS cycles.
    cur_vec = 102;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h55;
    PRDATA    = 32'hBAD0_BAD0;
    PREADY    = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    for (int j = 0; j < 15; j++) begin
      @(negedge PCLK);
      chk("tmo_wait_psel", PSEL, 1);
      chk("tmo_wait_rsp_valid", rsp_valid, 0);
    end
    @(negedge PCLK);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_rdata", rsp_rdata, 0);
    chk("tmo_psel", PSEL, 0);
    chk("tmo_penable", PENABLE, 0);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("tmo_pop", rsp_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
